rs_issue: RTL and testbench
===========================

// Module: rs_issue
// PURPOSE
//  Reservation/issue station feeding the register file and ALU. Buffers decoded
//  micro-ops in a FIFO and presents each op's source addresses and PC for the
//  register file's read stage. It then holds the op in a one-entry execute
//  register and drives the register file's write controls for that op.
//  Sits between the instruction decoder and the regfile/ALU pair.
// PARAMETERS
//  DEPTH  4  FIFO entries (power of two, >=2)
//  AW     2  log2(DEPTH); occupancy counter is AW+1 bits
// PORTS
//  clk           in   1   clock, all state on rising edge
//  rst           in   1   synchronous reset, active-high
//  uop_valid     in   1   decoder offers a micro-op
//  uop_ready     out  1   FIFO accepts; transfer = uop_valid & uop_ready
//  uop_a         in   3   source A register address
//  uop_b         in   3   source B register address
//  uop_dst       in   3   destination register address
//  uop_wr        in   1   op writes uop_dst
//  uop_wf        in   1   op writes flags
//  uop_op        in   4   ALU opcode
//  uop_pc        in   16  PC of the op
//  ex_hold       in   1   ALU result not final this cycle (multi-cycle op)
//  flush         in   1   discard all queued and executing ops
//  r_a_addr      out  3   regfile read address A
//  r_b_addr      out  3   regfile read address B
//  r_pc          out  16  PC value for reads of address 3'b011
//  ex_valid      out  1   execute register holds a live op
//  ex_op         out  4   ALU opcode of the executing op
//  dest_r_wr     out  1   regfile write enable
//  dest_r_addr   out  3   regfile write address
//  dest_w_flags  out  1   flags write enable
//  pc_load       out  1   executing op retires a write to register 3'b011
// BEHAVIOUR
//  Reset: FIFO empty, ex_valid=0, ex_op=0, dest_r_addr=0, dest_r_wr=0,
//   dest_w_flags=0, pc_load=0, r_a_addr=0, r_b_addr=0, r_pc=0, uop_ready=0
//   while rst=1. The first cycle after rst deasserts has uop_ready=1.
//  uop_ready = ~full & ~rst. No combinational path from issue to uop_ready.
//   Enqueue and issue can happen in the same cycle.
//  retire = ex_valid & ~ex_hold. issue = ~empty & ~flush & ~pc_load
//   & (~ex_valid | ~ex_hold).
//  Issue cycle N: r_a_addr/r_b_addr/r_pc come combinationally from the head
//   entry. At the edge the head pops into the execute register.
//  Cycle N+1: operands are in the regfile, ex_valid=1, and ex_op/dest fields
//   come from the execute register. Back-to-back dependent ops need no stall
//   because the regfile bypasses alu_r when read addr == dest_r_addr & dest_r_wr.
//  If ex_hold=1: r_a_addr/r_b_addr/r_pc are driven from the execute register's
//   saved copies. The regfile re-reads the same operands every cycle of the hold.
//  If no issue and ~ex_valid: read address outputs are 0.
//  dest_r_wr    = retire & ex_wr & ~flush
//  dest_w_flags = retire & ex_wf & ~flush
//  pc_load      = dest_r_wr & (dest_r_addr == 3'b011)
//  After retire with no issue, ex_valid clears at the edge.
//  Flush, or pc_load, takes effect at the edge: FIFO is emptied, ex_valid=0,
//   and any enqueue in that cycle is dropped. pc_load still writes the regfile.
//  flush during ex_hold kills the held op; no write is ever emitted for it.
//  FIFO pointers wrap modulo DEPTH. Count is never above DEPTH or below 0.
//  Reset mid-hold or with a full FIFO returns to the reset state in one edge.
// TESTING
//  1 Enqueue ops (a=1,b=2,dst=4) and (a=4,b=0,dst=5) back to back ->
//    r_a_addr=1 at cycle N, then r_a_addr=4 at N+1 with dest_r_wr=1,
//    dest_r_addr=4 at N+1 (bypass case), and dest_r_addr=5 at N+2.
//  2 Fill DEPTH=4 with ex_hold=1 -> uop_ready=0 after 5 accepts
//    (4 queued + 1 executing). Release hold -> one retire per cycle,
//    uop_ready=1 on the next cycle.
//  3 ex_hold=1 for 3 cycles on op (a=6,b=7) -> r_a_addr=6, r_b_addr=7 and
//    dest_r_wr=0 each cycle. dest_r_wr=1 only in the cycle hold drops.
//  4 Op dst=3, wr=1 with 2 ops queued -> pc_load=1 for one cycle,
//    next cycle ex_valid=0 and FIFO empty. No further dest_r_wr.
//  5 flush with executing op (wr=1, wf=1) and uop_valid=1 ->
//    dest_r_wr=0 and dest_w_flags=0 that cycle, then empty with the new op dropped.
//  6 rst asserted with full FIFO and ex_hold=1 -> all outputs 0 next cycle.
//    Push/pop 9 ops through DEPTH=4 -> dest_r_addr order preserved across wrap.

Source files
------------

// File: rtl/rs_issue.sv
// Reservation/issue station: micro-op FIFO feeding a one-entry execute register
// that presents regfile read addresses and drives regfile/flag write controls.
module rs_issue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        uop_valid,
   output logic        uop_ready,
   input  logic [2:0]  uop_a,
   input  logic [2:0]  uop_b,
   input  logic [2:0]  uop_dst,
   input  logic        uop_wr,
   input  logic        uop_wf,
   input  logic [3:0]  uop_op,
   input  logic [15:0] uop_pc,
   input  logic        ex_hold,
   input  logic        flush,
   output logic [2:0]  r_a_addr,
   output logic [2:0]  r_b_addr,
   output logic [15:0] r_pc,
   output logic        ex_valid,
   output logic [3:0]  ex_op,
   output logic        dest_r_wr,
   output logic [2:0]  dest_r_addr,
   output logic        dest_w_flags,
   output logic        pc_load
);

   localparam int unsigned CW = AW + 1;

   typedef struct packed {
      logic [2:0]  a;
      logic [2:0]  b;
      logic [2:0]  dst;
      logic        wr;
      logic        wf;
      logic [3:0]  op;
      logic [15:0] pc;
   } uop_t;

   uop_t          mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   uop_t          ex_q;
   logic          ex_valid_q;

   uop_t          in_uop;
   uop_t          head;
   logic          full;
   logic          empty;
   logic          retire;
   logic          issue;
   logic          push;
   logic          kill;

   assign in_uop = '{a: uop_a, b: uop_b, dst: uop_dst, wr: uop_wr,
                     wf: uop_wf, op: uop_op, pc: uop_pc};
   assign head   = mem[rd_ptr];
   assign full   = (count == CW'(DEPTH));
   assign empty  = (count == '0);

   // Only the occupancy register and rst feed uop_ready, never issue.
   assign uop_ready = ~full & ~rst;

   // Retire/issue decisions and regfile write controls for the executing op.
   always_comb begin
      retire       = ex_valid_q & ~ex_hold & ~rst;
      dest_r_wr    = retire & ex_q.wr & ~flush;
      dest_w_flags = retire & ex_q.wf & ~flush;
      pc_load      = dest_r_wr & (ex_q.dst == 3'b011);
      kill         = flush | pc_load;
      issue        = ~rst & ~empty & ~kill & (~ex_valid_q | ~ex_hold);
      push         = uop_valid & uop_ready & ~kill;
   end

   // Read addresses: head entry on issue, saved copies while holding, else 0.
   always_comb begin
      r_a_addr = '0;
      r_b_addr = '0;
      r_pc     = '0;
      if (issue) begin
         r_a_addr = head.a;
         r_b_addr = head.b;
         r_pc     = head.pc;
      end else if (ex_valid_q & ex_hold & ~rst) begin
         r_a_addr = ex_q.a;
         r_b_addr = ex_q.b;
         r_pc     = ex_q.pc;
      end
   end

   assign ex_valid    = ex_valid_q;
   assign ex_op       = ex_q.op;
   assign dest_r_addr = ex_q.dst;

   // FIFO storage; no reset needed since occupancy guards every read.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_uop;
   end

   // FIFO pointers and occupancy; flush or pc_load empties the queue.
   always_ff @(posedge clk) begin
      if (rst | kill) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)  wr_ptr <= wr_ptr + AW'(1);
         if (issue) rd_ptr <= rd_ptr + AW'(1);
         case ({push, issue})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Execute register; fields are cleared whenever it goes empty.
   always_ff @(posedge clk) begin
      if (rst | kill) begin
         ex_valid_q <= 1'b0;
         ex_q       <= '0;
      end else if (issue) begin
         ex_valid_q <= 1'b1;
         ex_q       <= head;
      end else if (retire) begin
         ex_valid_q <= 1'b0;
         ex_q       <= '0;
      end
   end

endmodule

// File: tb/tb_rs_issue.sv
// Self-checking bench for rs_issue: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_rs_issue;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned AW    = 2;

   typedef struct packed {
      logic [2:0]  a;
      logic [2:0]  b;
      logic [2:0]  dst;
      logic        wr;
      logic        wf;
      logic [3:0]  op;
      logic [15:0] pc;
   } uop_t;

   logic        clk;
   logic        rst;
   logic        uop_valid;
   logic        uop_ready;
   logic [2:0]  uop_a;
   logic [2:0]  uop_b;
   logic [2:0]  uop_dst;
   logic        uop_wr;
   logic        uop_wf;
   logic [3:0]  uop_op;
   logic [15:0] uop_pc;
   logic        ex_hold;
   logic        flush;
   logic [2:0]  r_a_addr;
   logic [2:0]  r_b_addr;
   logic [15:0] r_pc;
   logic        ex_valid;
   logic [3:0]  ex_op;
   logic        dest_r_wr;
   logic [2:0]  dest_r_addr;
   logic        dest_w_flags;
   logic        pc_load;

   int total = 0;
   int bad   = 0;

   // Reference model state: queued ops and the executing op.
   uop_t q[$];
   bit   m_ev;
   uop_t m_ex;

   rs_issue #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .rst(rst), .uop_valid(uop_valid), .uop_ready(uop_ready),
      .uop_a(uop_a), .uop_b(uop_b), .uop_dst(uop_dst), .uop_wr(uop_wr),
      .uop_wf(uop_wf), .uop_op(uop_op), .uop_pc(uop_pc), .ex_hold(ex_hold),
      .flush(flush), .r_a_addr(r_a_addr), .r_b_addr(r_b_addr), .r_pc(r_pc),
      .ex_valid(ex_valid), .ex_op(ex_op), .dest_r_wr(dest_r_wr),
      .dest_r_addr(dest_r_addr), .dest_w_flags(dest_w_flags), .pc_load(pc_load)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic uop_t mk(input int a, input int b, input int dst,
                               input bit wr, input bit wf);
      uop_t u;
      u.a   = 3'(a);
      u.b   = 3'(b);
      u.dst = 3'(dst);
      u.wr  = wr;
      u.wf  = wf;
      u.op  = 4'(a + b + dst);
      u.pc  = 16'(16'h1000 + a * 64 + b * 8 + dst);
      return u;
   endfunction

   function automatic uop_t rnd();
      return uop_t'(31'($urandom));
   endfunction

   // One cycle: drive inputs after the falling edge, check outputs, advance model.
   task automatic step(input logic v, input uop_t u, input logic h,
                       input logic f, input logic r);
      int          n;
      logic        e_ready, e_ret, e_wr, e_wf, e_pcl, e_iss;
      logic [2:0]  e_a, e_b;
      logic [15:0] e_pc;
      @(negedge clk);
      uop_valid = v;
      uop_a = u.a; uop_b = u.b; uop_dst = u.dst; uop_wr = u.wr;
      uop_wf = u.wf; uop_op = u.op; uop_pc = u.pc;
      ex_hold = h; flush = f; rst = r;
      #1;
      n       = q.size();
      e_ready = (n < DEPTH) && !r;
      e_ret   = m_ev && !h && !r;
      e_wr    = e_ret && m_ex.wr && !f;
      e_wf    = e_ret && m_ex.wf && !f;
      e_pcl   = e_wr && (m_ex.dst == 3'd3);
      e_iss   = !r && (n > 0) && !f && !e_pcl && (!m_ev || !h);
      e_a = '0; e_b = '0; e_pc = '0;
      if (e_iss) begin
         e_a = q[0].a; e_b = q[0].b; e_pc = q[0].pc;
      end else if (m_ev && h && !r) begin
         e_a = m_ex.a; e_b = m_ex.b; e_pc = m_ex.pc;
      end
      chk("uop_ready",    32'(uop_ready),    32'(e_ready));
      chk("r_a_addr",     32'(r_a_addr),     32'(e_a));
      chk("r_b_addr",     32'(r_b_addr),     32'(e_b));
      chk("r_pc",         32'(r_pc),         32'(e_pc));
      chk("ex_valid",     32'(ex_valid),     32'(m_ev));
      chk("ex_op",        32'(ex_op),        32'(m_ev ? m_ex.op : 4'd0));
      chk("dest_r_addr",  32'(dest_r_addr),  32'(m_ev ? m_ex.dst : 3'd0));
      chk("dest_r_wr",    32'(dest_r_wr),    32'(e_wr));
      chk("dest_w_flags", 32'(dest_w_flags), 32'(e_wf));
      chk("pc_load",      32'(pc_load),      32'(e_pcl));
      if (r || f || e_pcl) begin
         q.delete();
         m_ev = 1'b0;
      end else begin
         if (e_iss) begin
            m_ex = q.pop_front();
            m_ev = 1'b1;
         end else if (e_ret) begin
            m_ev = 1'b0;
         end
         if (v && e_ready) q.push_back(u);
      end
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) step(1'b0, rnd(), 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      uop_t z;
      z = '0;
      rst = 1'b1; uop_valid = 1'b0; ex_hold = 1'b0; flush = 1'b0;
      uop_a = '0; uop_b = '0; uop_dst = '0; uop_wr = 1'b0; uop_wf = 1'b0;
      uop_op = '0; uop_pc = '0;
      q.delete(); m_ev = 1'b0; m_ex = '0;

      // Reset state.
      step(1'b1, rnd(), 1'b1, 1'b0, 1'b1);
      step(1'b0, z, 1'b0, 1'b0, 1'b1);
      chk("rst_ready", 32'(uop_ready), 32'd0);
      chk("rst_exv",   32'(ex_valid),  32'd0);

      // Back-to-back dependent ops.
      step(1'b1, mk(1, 2, 4, 1, 0), 1'b0, 1'b0, 1'b0);
      chk("t1_ready_first", 32'(uop_ready), 32'd1);
      step(1'b1, mk(4, 0, 5, 1, 0), 1'b0, 1'b0, 1'b0);
      chk("t1_ra_n", 32'(r_a_addr), 32'd1);
      step(1'b0, z, 1'b0, 1'b0, 1'b0);
      chk("t1_ra_n1",  32'(r_a_addr),    32'd4);
      chk("t1_wr_n1",  32'(dest_r_wr),   32'd1);
      chk("t1_dst_n1", 32'(dest_r_addr), 32'd4);
      step(1'b0, z, 1'b0, 1'b0, 1'b0);
      chk("t1_dst_n2", 32'(dest_r_addr), 32'd5);
      idle(2);

      // Fill under hold: 5 accepts, then back-pressure, then release.
      for (int i = 0; i < 5; i++) step(1'b1, mk(i, i + 1, (i < 3) ? i : i + 1, 1, 0), 1'b1, 1'b0, 1'b0);
      step(1'b1, mk(7, 7, 7, 1, 0), 1'b1, 1'b0, 1'b0);
      chk("t2_full_ready", 32'(uop_ready), 32'd0);
      step(1'b0, z, 1'b0, 1'b0, 1'b0);
      chk("t2_release_wr", 32'(dest_r_wr), 32'd1);
      step(1'b0, z, 1'b0, 1'b0, 1'b0);
      chk("t2_ready_again", 32'(uop_ready), 32'd1);
      idle(6);

      // Three-cycle hold re-reads the same operands.
      step(1'b1, mk(6, 7, 2, 1, 1), 1'b0, 1'b0, 1'b0);
      step(1'b0, z, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, z, 1'b1, 1'b0, 1'b0);
         chk("t3_hold_ra", 32'(r_a_addr),  32'd6);
         chk("t3_hold_rb", 32'(r_b_addr),  32'd7);
         chk("t3_hold_wr", 32'(dest_r_wr), 32'd0);
      end
      step(1'b0, z, 1'b0, 1'b0, 1'b0);
      chk("t3_drop_wr", 32'(dest_r_wr), 32'd1);
      idle(2);

      // Write to register 3 triggers pc_load and empties the station.
      step(1'b1, mk(1, 1, 3, 1, 0), 1'b0, 1'b0, 1'b0);
      step(1'b1, mk(2, 2, 4, 1, 0), 1'b0, 1'b0, 1'b0);
      step(1'b1, mk(3, 3, 5, 1, 0), 1'b0, 1'b0, 1'b0);
      chk("t4_pc_load", 32'(pc_load), 32'd1);
      step(1'b0, z, 1'b0, 1'b0, 1'b0);
      chk("t4_exv_after", 32'(ex_valid),  32'd0);
      chk("t4_no_wr",     32'(dest_r_wr), 32'd0);
      chk("t4_no_issue",  32'(r_a_addr),  32'd0);
      idle(2);

      // Flush kills an executing op and drops a same-cycle enqueue.
      step(1'b1, mk(5, 6, 6, 1, 1), 1'b0, 1'b0, 1'b0);
      step(1'b1, mk(2, 3, 1, 1, 1), 1'b0, 1'b0, 1'b0);
      step(1'b1, mk(4, 4, 2, 1, 1), 1'b0, 1'b1, 1'b0);
      chk("t5_flush_wr", 32'(dest_r_wr),    32'd0);
      chk("t5_flush_wf", 32'(dest_w_flags), 32'd0);
      step(1'b0, z, 1'b0, 1'b0, 1'b0);
      chk("t5_empty_exv", 32'(ex_valid), 32'd0);
      chk("t5_empty_ra",  32'(r_a_addr), 32'd0);
      idle(1);

      // Reset with a full FIFO and a held op.
      for (int i = 0; i < 5; i++) step(1'b1, mk(i + 1, i, 6, 1, 1), 1'b1, 1'b0, 1'b0);
      step(1'b1, z, 1'b1, 1'b0, 1'b1);
      step(1'b0, z, 1'b1, 1'b0, 1'b1);
      chk("t6_rst_exv",   32'(ex_valid),    32'd0);
      chk("t6_rst_ready", 32'(uop_ready),   32'd0);
      chk("t6_rst_dst",   32'(dest_r_addr), 32'd0);
      step(1'b0, z, 1'b0, 1'b0, 1'b0);
      chk("t6_post_ready", 32'(uop_ready), 32'd1);

      // Nine ops through the FIFO so the pointers wrap.
      for (int i = 0; i < 9; i++) step(1'b1, mk(i % 8, (i + 3) % 8, (i % 2) ? 5 : 2 + (i % 3) * 2, 1, 0), 1'b0, 1'b0, 1'b0);
      idle(4);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         step(1'($urandom_range(0, 9) < 7), rnd(), 1'($urandom_range(0, 9) < 3),
              1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 49) == 0));
      end
      idle(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
